// File: rtl/sar_adc_diff.sv
// Cycle-based differential SAR ADC model: samples (vip - vin) + VOS on start,
// resolves one bit per clock against an ideal DAC, emits offset-binary dout.
module sar_adc_diff #(
  parameter int  NBIT = 8,
  parameter real VREF = 1.0,
  parameter real VOS  = 0.0
) (
  input  logic            clk,
  input  logic            reset,
  input  real             vip,
  input  real             vin,
  input  logic            start,
  output logic            busy,
  output logic            valid,
  output logic [NBIT-1:0] dout,
  output logic [15:0]     conv_cnt
);

  localparam int  IDXW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam real HALF = 2.0 ** (NBIT - 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t          state_q, state_d;
  real             vhold_q, vhold_d;
  logic [NBIT-1:0] code_q,  code_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic            busy_d,  valid_d;
  logic [NBIT-1:0] dout_d;
  logic [15:0]     cnt_d;

  logic [NBIT-1:0] trial;
  real             vth;

  // Ideal DAC level for the current trial code; equality keeps the bit.
  assign trial = code_q | (NBIT'(1) << idx_q);
  assign vth   = VREF * (real'(trial) - HALF) / HALF;

  always_comb begin
    state_d = state_q;
    vhold_d = vhold_q;
    code_d  = code_q;
    idx_d   = idx_q;
    busy_d  = busy;
    valid_d = 1'b0;
    dout_d  = dout;
    cnt_d   = conv_cnt;
    case (state_q)
      IDLE: begin
        if (start) begin
          vhold_d = (vip - vin) + VOS;
          code_d  = '0;
          idx_d   = IDXW'(NBIT - 1);
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (vhold_q >= vth) code_d = trial;
        if (idx_q == '0) begin
          dout_d  = code_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = conv_cnt + 16'd1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vhold_q  <= 0.0;
      code_q   <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      dout     <= '0;
      conv_cnt <= '0;
    end else begin
      state_q  <= state_d;
      vhold_q  <= vhold_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      valid    <= valid_d;
      dout     <= dout_d;
      conv_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sar_adc_diff.sv
// Directed bench for sar_adc_diff: vector table plus hand-written sequences
// for hold/ignore, continuous sinusoid sampling, reset abort and offset.
module tb_sar_adc_diff;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  real         vip = 0.0;
  real         vin = 0.0;
  logic        busy, valid, busy_b, valid_b;
  logic [7:0]  dout, dout_b;
  logic [15:0] conv_cnt, cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sar_adc_diff #(.NBIT(8), .VREF(1.0), .VOS(0.0)) dut (
    .clk(clk), .reset(reset), .vip(vip), .vin(vin), .start(start),
    .busy(busy), .valid(valid), .dout(dout), .conv_cnt(conv_cnt)
  );

  sar_adc_diff #(.NBIT(8), .VREF(1.0), .VOS(0.0078125)) dut_os (
    .clk(clk), .reset(reset), .vip(vip), .vin(vin), .start(start),
    .busy(busy_b), .valid(valid_b), .dout(dout_b), .conv_cnt(cnt_b)
  );

  typedef struct {
    real        vp;
    real        vn;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ideal transfer function: largest code whose DAC level is <= d.
  function automatic logic [7:0] model(input real d);
    int k = 0;
    for (int j = 1; j < 256; j++)
      if (d >= (j - 128) / 128.0) k = j;
    return k[7:0];
  endfunction

  // Start one conversion and wait (bounded) for valid; lat counts edges after E0.
  task automatic run_conv(input real vp, input real vn, output int lat);
    vip = vp;
    vin = vn;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
    check("busy_low_with_valid", busy, 0);
  endtask

  initial begin
    int lat;
    int nval;
    int base;
    real d;
    logic [7:0] q [$];

    vecs[0] = '{0.5,    0.5,  8'h80};
    vecs[1] = '{1.0,    0.25, 8'hE0};
    vecs[2] = '{0.375,  0.5,  8'h70};
    vecs[3] = '{0.0,    1.0,  8'h00};
    vecs[4] = '{1.2,    0.0,  8'hFF};
    vecs[5] = '{-0.75,  0.75, 8'h00};
    vecs[6] = '{0.9999, 0.0,  8'hFF};

    // Reset overrides start.
    reset = 1'b1;
    start = 1'b1;
    vip = 0.5;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_dout", dout, 0);
      check("rst_cnt", conv_cnt, 0);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Table vectors; each next start lands in the previous valid cycle.
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].vp, vecs[i].vn, lat);
      check("vec_latency", lat, 8);
      check("vec_dout", dout, vecs[i].exp);
      check("vec_cnt", conv_cnt, i + 1);
    end
    tick();
    check("valid_one_cycle", valid, 0);
    check("dout_held", dout, 8'hFF);

    // Hold and ignore: input change and start at E3 must not disturb result.
    vip = 0.5; vin = 0.0; start = 1'b1;
    tick();
    vip = 0.0; vin = 0.5;
    nval = 0;
    for (int e = 1; e <= 8; e++) begin
      start = (e == 3);
      tick();
      nval += valid;
    end
    start = 1'b0;
    check("hold_valid_e8", valid, 1);
    check("hold_single_valid", nval, 1);
    check("hold_dout", dout, 8'hC0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e9_busy", busy, 1);
    lat = 0;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
    check("e9_latency", lat, 8);
    check("e9_dout", dout, 8'h40);
    check("e9_cnt", conv_cnt, 9);
    tick();
    tick();

    // Continuous start with a 100 ns sinusoid, differential outputs.
    base = 9;
    nval = 0;
    for (int c = 0; c < 108; c++) begin
      vip = 0.45 * $sin(2.0 * 3.14159265358979 * (c * 10.0) / 100.0);
      vin = -vip;
      start = 1'b1;
      if (c % 9 == 0) begin
        d = vip - vin;
        q.push_back(model(d));
      end
      tick();
      if (c % 9 == 8) begin
        check("sin_valid", valid, 1);
        if (q.size() > 0) check("sin_dout", dout, q.pop_front());
        nval++;
        check("sin_cnt", conv_cnt, base + nval);
      end else begin
        check("sin_no_valid", valid, 0);
      end
    end
    start = 1'b0;
    tick();
    check("sin_busy_done", busy, 0);

    // Reset at E4 aborts the conversion.
    vip = 0.5; vin = 0.0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    check("abort_cnt", conv_cnt, 0);
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nval += valid;
    end
    check("abort_no_valid", nval, 0);

    // Normal conversion after abort; offset instance sees +1 LSB.
    run_conv(0.0, 0.0, lat);
    check("post_abort_latency", lat, 8);
    check("post_abort_dout", dout, 8'h80);
    check("post_abort_cnt", conv_cnt, 1);
    check("vos_valid", valid_b, 1);
    check("vos_dout", dout_b, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
